// File: rtl/drive_gpio.sv
// Scripted GPIO pad driver: replays queued (delay, value) entries onto the core's
// input bus, looping back pins the core drives as outputs.
module drive_gpio #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DLY_W       = 16,
    parameter logic [7:0]  RESET_VALUE = 8'h00
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     LD_STB_I,
    input  logic [DLY_W-1:0]         LD_DELAY_I,
    input  logic [7:0]               LD_VALUE_I,
    output logic                     LD_ACK_O,
    output logic                     FULL_O,
    output logic [$clog2(DEPTH):0]   LEVEL_O,
    input  logic                     START_I,
    input  logic                     ABORT_I,
    output logic                     BUSY_O,
    output logic                     DONE_O,
    output logic [15:0]              APPLIED_O,
    input  logic [7:0]               DIR_I,
    input  logic [7:0]               OUT_I,
    output logic [7:0]               IN_O
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t             state_q, state_d;
    logic [DLY_W+7:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        level_q, level_d;
    logic [DLY_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         cur_q, cur_d;
    logic [7:0]         drv_q, drv_d;
    logic [15:0]        applied_q, applied_d;
    logic               done_q, done_d;
    logic               ack_q;
    logic               full, push, pop;
    logic [DLY_W-1:0]   head_dly;
    logic [7:0]         head_val;

    assign full     = (level_q == LW'(DEPTH));
    assign push     = LD_STB_I && !full && !ABORT_I;
    assign head_dly = mem_q[rd_ptr_q][DLY_W+7:8];
    assign head_val = mem_q[rd_ptr_q][7:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_d     = cur_q;
        drv_d     = drv_q;
        applied_d = applied_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        if (ABORT_I) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (START_I && level_q != '0) begin
                        pop     = 1'b1;
                        cnt_d   = head_dly;
                        cur_d   = head_val;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DLY_W'(1);
                    end else begin
                        // Apply edge: chain straight into the next entry when one is queued.
                        drv_d     = cur_q;
                        applied_d = applied_q + 16'd1;
                        if (level_q != '0) begin
                            pop   = 1'b1;
                            cnt_d = head_dly;
                            cur_d = head_val;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        level_d = level_q;
        if (ABORT_I)
            level_d = '0;
        else if (push && !pop)
            level_d = level_q + LW'(1);
        else if (pop && !push)
            level_d = level_q - LW'(1);
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            cnt_q     <= '0;
            cur_q     <= '0;
            drv_q     <= RESET_VALUE;
            applied_q <= '0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            cur_q     <= cur_d;
            drv_q     <= drv_d;
            applied_q <= applied_d;
            done_q    <= done_d;
            ack_q     <= push;
            if (ABORT_I) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (push) mem_q[wr_ptr_q] <= {LD_DELAY_I, LD_VALUE_I};
    end

    assign LD_ACK_O  = ack_q;
    assign FULL_O    = full;
    assign LEVEL_O   = level_q;
    assign BUSY_O    = (state_q == ST_WAIT);
    assign DONE_O    = done_q;
    assign APPLIED_O = applied_q;
    assign IN_O      = (DIR_I & OUT_I) | (~DIR_I & drv_q);

endmodule

// File: tb/tb_drive_gpio.sv
// Bench for drive_gpio: directed scenarios plus random traffic, checked every cycle
// against a queue-based model that schedules applies by absolute cycle number.
module tb_drive_gpio;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned DLY_W = 16;
    localparam logic [7:0]  RV    = 8'h00;

    logic        clk = 1'b0;
    logic        rst, stb, start, abort;
    logic [15:0] dly;
    logic [7:0]  val, dir, outv;
    logic        ack, full, busy, done;
    logic [4:0]  level;
    logic [15:0] applied;
    logic [7:0]  in_o;

    drive_gpio #(.DEPTH(DEPTH), .DLY_W(DLY_W), .RESET_VALUE(RV)) dut (
        .CLK_I(clk), .RST_I(rst), .LD_STB_I(stb), .LD_DELAY_I(dly), .LD_VALUE_I(val),
        .LD_ACK_O(ack), .FULL_O(full), .LEVEL_O(level), .START_I(start), .ABORT_I(abort),
        .BUSY_O(busy), .DONE_O(done), .APPLIED_O(applied), .DIR_I(dir), .OUT_I(outv),
        .IN_O(in_o)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: entries live in a queue; an entry popped at cycle c applies at c+D+1.
    typedef struct {logic [15:0] d; logic [7:0] v;} ent_t;
    ent_t        m_q[$];
    ent_t        m_cur;
    bit          m_busy, m_done, m_ack;
    longint      m_cyc, m_apply_at;
    logic [7:0]  m_drv;
    int unsigned m_applied;

    task automatic model_reset();
        m_q.delete();
        m_busy = 0; m_done = 0; m_ack = 0;
        m_drv = RV; m_applied = 0; m_apply_at = -1;
    endtask

    task automatic model_step();
        int unsigned lvl;
        m_cyc++;
        m_done = 0;
        m_ack  = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (abort) begin
            m_q.delete();
            m_busy = 0;
            return;
        end
        lvl = m_q.size();
        if (!m_busy) begin
            if (start && lvl > 0) begin
                m_cur = m_q.pop_front();
                m_apply_at = m_cyc + m_cur.d + 1;
                m_busy = 1;
            end
        end else if (m_cyc == m_apply_at) begin
            m_drv = m_cur.v;
            m_applied = (m_applied + 1) % 65536;
            if (lvl > 0) begin
                m_cur = m_q.pop_front();
                m_apply_at = m_cyc + m_cur.d + 1;
            end else begin
                m_busy = 0;
                m_done = 1;
            end
        end
        if (stb && lvl < DEPTH) begin
            m_q.push_back('{d: dly, v: val});
            m_ack = 1;
        end
    endtask

    task automatic compare_all();
        check_eq("in_o",    in_o,    (dir & outv) | (~dir & m_drv));
        check_eq("busy",    busy,    m_busy);
        check_eq("done",    done,    m_done);
        check_eq("ack",     ack,     m_ack);
        check_eq("level",   level,   m_q.size());
        check_eq("full",    full,    m_q.size() == DEPTH);
        check_eq("applied", applied, m_applied);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic push(input logic [15:0] d, input logic [7:0] v);
        stb = 1; dly = d; val = v;
        step();
        stb = 0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    initial begin
        int unsigned acks;
        rst = 1; stb = 0; start = 0; abort = 0; dly = '0; val = '0;
        dir = 8'h00; outv = 8'h00; m_cyc = 0;
        model_reset();
        #1;
        check_eq("rst_in_async", in_o, 8'h00);
        idle(2);
        rst = 0;
        idle(1);
        check_eq("rst_in", in_o, 8'h00);
        dir = 8'hF0; outv = 8'hA5;
        #1;
        check_eq("pad_mix", in_o, 8'hA0);

        // Basic replay
        push(16'd3, 8'h11); push(16'd0, 8'h22); push(16'd1, 8'h33);
        start = 1; step(); start = 0;
        idle(10);
        check_eq("basic_applied", applied, 3);

        // Fill and overflow
        acks = 0;
        for (int unsigned i = 0; i < 17; i++) begin
            push(16'(i), 8'(i));
            if (ack) acks++;
        end
        idle(1);
        check_eq("ovf_acks", acks, 16);
        check_eq("ovf_full", full, 1);
        check_eq("ovf_level", level, 16);
        abort = 1; step(); abort = 0;

        // Push while the only entry is waiting
        push(16'd5, 8'h55);
        start = 1; step(); start = 0;
        idle(2);
        push(16'd0, 8'h44);
        idle(10);

        // Abort mid-replay, then a START on an empty FIFO
        for (int unsigned i = 0; i < 4; i++) push(16'd10, 8'($urandom));
        start = 1; step(); start = 0;
        idle(3);
        abort = 1; step(); abort = 0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_level", level, 0);
        start = 1; step(); start = 0;
        idle(3);

        // Asynchronous reset mid-replay
        push(16'd20, 8'h77);
        start = 1; step(); start = 0;
        idle(3);
        #2 rst = 1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_level", level, 0);
        check_eq("arst_applied", applied, 0);
        check_eq("arst_in", in_o, (dir & outv) | (~dir & RV));
        step();
        rst = 0;
        step();

        // Random traffic
        for (int unsigned i = 0; i < 3000; i++) begin
            stb   = ($urandom % 3) == 0;
            dly   = 16'($urandom % 5);
            val   = 8'($urandom);
            start = ($urandom % 8) == 0;
            abort = ($urandom % 80) == 0;
            if (($urandom % 16) == 0) begin
                dir  = 8'($urandom);
                outv = 8'($urandom);
            end
            step();
        end
        stb = 0; start = 0; abort = 0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/drive_gpio.md
# drive_gpio

Simulation-side GPIO stimulus generator: the driving counterpart of the GPIO listener. It holds a small script of (delay, value) entries and replays them onto the GPIO input bus of the device under test. Pins configured as outputs are looped back from the core's output register, so the core always reads a consistent pad value. It sits in the sim testbench between the bench sequencer and the GPIO peripheral's pad-side ports.

## Interface
- DEPTH, 16, script FIFO entries (power of two, 2..256)
- DLY_W, 16, delay field width
- RESET_VALUE, 8'h00, value driven on input-direction pins after reset
- CLK_I  in  1  clock, rising edge
- RST_I  in  1  reset, asynchronous, active-high
- LD_STB_I  in  1  push one script entry
- LD_DELAY_I  in  DLY_W  entry delay in cycles
- LD_VALUE_I  in  8  entry pin value
- LD_ACK_O  out  1  registered; push accepted (high the cycle after the LD_STB_I edge)
- FULL_O  out  1  FIFO full (combinational from level)
- LEVEL_O  out  log2(DEPTH)+1  FIFO occupancy
- START_I  in  1  begin replay
- ABORT_I  in  1  flush script, stop replay
- BUSY_O  out  1  replay in progress
- DONE_O  out  1  one-cycle pulse, last entry applied
- APPLIED_O  out  16  entries applied since reset, wraps
- DIR_I  in  8  core direction, 1 = output
- OUT_I  in  8  core output register
- IN_O  out  8  pad value presented to the core input

## Operation
- Pad resolution (combinational): IN_O = (DIR_I & OUT_I) | (~DIR_I & drv), where drv is the internal 8-bit drive register.
- FIFO push: on an edge with LD_STB_I=1 and level<DEPTH, store {delay, value}, level+1, LD_ACK_O=1 for the following cycle. When full, the push is dropped and LD_ACK_O=0. Pushes are legal in any state.
- FSM has two states: IDLE and WAIT. A counter cnt (DLY_W bits) is used in WAIT.
- In IDLE, when START_I=1 and level>0: pop the head, cnt<=delay, go to WAIT. START_I with an empty FIFO is ignored, with no DONE pulse.
- In WAIT with cnt≠0: cnt<=cnt-1.
- In WAIT with cnt==0, this is the apply edge:
  - drv<=entry value and APPLIED_O+1.
  - If level>0 (occupancy before this edge), pop the next entry and load cnt, staying in WAIT.
  - Otherwise go to IDLE and assert DONE_O for one cycle.
- START_I while in WAIT is ignored.
- ABORT_I has priority over everything, including a push on the same edge. It empties the FIFO, returns to IDLE, and gives no DONE pulse. drv and APPLIED_O are retained.
- Simultaneous push and pop: both take effect. The level is unchanged, and the pushed entry lands behind the existing ones.
- A push on the same edge that the FSM finds the FIFO empty is not seen by that edge. Replay ends, and the entry waits for the next START_I.
- BUSY_O = (state==WAIT).

## Timing
- Reset values: IN_O = (DIR_I&OUT_I)|(~DIR_I&RESET_VALUE), drv=RESET_VALUE, state IDLE, FIFO empty, LEVEL_O=0, FULL_O=0, LD_ACK_O=0, BUSY_O=0, DONE_O=0, APPLIED_O=0, cnt=0.
- RST_I asserted mid-replay aborts immediately and asynchronously to the values above.
- With START_I sampled at edge t0, an entry with delay D is applied at edge t0+D+1. IN_O shows the new value in the cycle after that edge.
- Each subsequent entry with delay D' is applied D'+1 edges after the previous apply. D=0 entries therefore apply on consecutive cycles.
- DONE_O is high in the cycle following the final apply edge. BUSY_O falls in that same cycle.
- DIR_I and OUT_I changes reach IN_O with zero latency (combinational).
- LEVEL_O and FULL_O update one cycle after a push or pop edge.

## Test plan
- Reset: hold DIR_I=8'h00 and release RST_I → IN_O=8'h00, all status outputs 0. Then set DIR_I=8'hF0 with OUT_I=8'hA5 → IN_O=8'hA0 combinationally.
- Basic replay: push (3,8'h11),(0,8'h22),(1,8'h33), then START_I at t0 → IN_O=11 after edge t0+4, 22 after t0+5, 33 after t0+7. DONE_O pulses in the cycle after t0+7, and APPLIED_O=3.
- Full and overflow: push 17 entries with DEPTH=16 → 16 LD_ACK_O pulses, the 17th not acked, FULL_O=1, LEVEL_O=16.
- Mid-replay push: during a WAIT with delay 5 and no other queued entries, push (0,8'h44) → it is applied one edge after the first apply, with a single DONE_O at the end.
- Abort: push 4 entries with delay 10, START_I, then ABORT_I after 3 cycles → BUSY_O=0, LEVEL_O=0, no DONE_O, IN_O keeps its pre-start value. A following START_I is ignored.
- Async reset mid-replay: assert RST_I between clock edges while BUSY_O=1 → outputs return to reset values without waiting for a clock edge.
